// File: rtl/nx_fifo_pkg.sv
// nx_fifo_pkg: shared widths and error-flag encoding
// for the nx_fifo family.
package nx_fifo_pkg;

  localparam int ERR_W  = 2;
  localparam int ERR_UF = 0;
  localparam int ERR_OF = 1;

  typedef logic [ERR_W-1:0] err_t;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Pointer width never collapses to zero for a 1-entry array.
  function automatic int ptr_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/nx_fifo_flex_ctrl.sv
// nx_fifo_flex_ctrl: pointers, occupancy, flags
// and head-flop valid tracking for nx_fifo_flex.
module nx_fifo_flex_ctrl
  import nx_fifo_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int OUT_REG   = 0,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 1,
  parameter int ADEPTH    = (OUT_REG != 0) ? DEPTH - 1 : DEPTH,
  parameter int PW        = ptr_w(ADEPTH),
  parameter int CW        = cnt_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wen,
  input  logic          ren,
  input  logic          clear,
  output logic [PW-1:0] wptr,
  output logic [PW-1:0] rptr,
  output logic          arr_push,
  output logic          head_wr,
  output logic          head_ld,
  output logic          head_valid,
  output logic          empty,
  output logic          full,
  output logic          almost_empty,
  output logic          almost_full,
  output err_t          err,
  output logic [CW-1:0] used_slots,
  output logic [CW-1:0] free_slots
);

  if (AF_THRESH > DEPTH || AE_THRESH >= DEPTH || DEPTH < 2) begin : g_bad
    $error("nx_fifo_flex: illegal DEPTH/threshold parameters");
  end

  localparam logic [CW-1:0] DEP = CW'(DEPTH);
  localparam logic [CW-1:0] AF  = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE  = CW'(AE_THRESH);
  localparam logic [PW-1:0] LST = PW'(ADEPTH - 1);

  logic live;
  logic wr_acc;
  logic rd_acc;
  logic arr_pop;
  logic arr_empty;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == LST) ? '0 : p + 1'b1;
  endfunction

  assign empty        = (used_slots == '0);
  assign full         = (used_slots == DEP);
  assign almost_empty = (used_slots <= AE);
  assign almost_full  = (used_slots >= AF);
  assign free_slots   = DEP - used_slots;

  always_comb begin
    live      = rst_n && !clear;
    wr_acc    = live && wen && (!full || ren);
    rd_acc    = live && ren && !empty;
    arr_empty = (used_slots <= CW'(1));
    head_wr   = 1'b0;
    head_ld   = 1'b0;
    arr_pop   = rd_acc;
    arr_push  = wr_acc;
    if (OUT_REG != 0) begin
      // Head flop takes wdata directly when nothing is queued behind it.
      head_wr  = wr_acc && (empty || (rd_acc && arr_empty));
      head_ld  = rd_acc && !arr_empty;
      arr_pop  = head_ld;
      arr_push = wr_acc && !head_wr;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      wptr       <= '0;
      rptr       <= '0;
      used_slots <= '0;
      head_valid <= 1'b0;
      err        <= '0;
    end else begin
      if (arr_push) wptr <= nxt(wptr);
      if (arr_pop)  rptr <= nxt(rptr);
      if (wr_acc && !rd_acc)
        used_slots <= used_slots + 1'b1;
      else if (rd_acc && !wr_acc)
        used_slots <= used_slots - 1'b1;
      head_valid  <= (OUT_REG != 0) &&
                     (head_wr || head_ld || (head_valid && !rd_acc));
      err[ERR_UF] <= ren && empty;
      err[ERR_OF] <= wen && full && !ren;
    end
  end

endmodule

// File: rtl/nx_fifo_flex.sv
// nx_fifo_flex: parametrised FWFT synchronous FIFO,
// any depth, optional registered head.
module nx_fifo_flex
  import nx_fifo_pkg::*;
#(
  parameter int DEPTH            = 16,
  parameter int WIDTH            = 132,
  parameter int DATA_RESET       = 1,
  parameter int OUT_REG          = 0,
  parameter int AF_THRESH        = DEPTH - 2,
  parameter int AE_THRESH        = 1,
  parameter int UNDERFLOW_ASSERT = 1,
  parameter int OVERFLOW_ASSERT  = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wen,
  input  logic                      ren,
  input  logic                      clear,
  input  logic [WIDTH-1:0]          wdata,
  output logic [WIDTH-1:0]          rdata,
  output logic                      empty,
  output logic                      full,
  output logic                      almost_empty,
  output logic                      almost_full,
  output logic                      underflow,
  output logic                      overflow,
  output logic [cnt_w(DEPTH)-1:0]   used_slots,
  output logic [cnt_w(DEPTH)-1:0]   free_slots
);

  localparam int ADEPTH = (OUT_REG != 0) ? DEPTH - 1 : DEPTH;
  localparam int PW     = ptr_w(ADEPTH);

  logic [WIDTH-1:0] mem [ADEPTH];
  logic [WIDTH-1:0] arr_head;
  logic [WIDTH-1:0] raw;
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic             arr_push;
  logic             head_wr;
  logic             head_ld;
  logic             head_valid;
  logic             no_data;
  err_t             err;

  nx_fifo_flex_ctrl #(
    .DEPTH     (DEPTH),
    .OUT_REG   (OUT_REG),
    .AF_THRESH (AF_THRESH),
    .AE_THRESH (AE_THRESH)
  ) u_ctrl (
    .clk          (clk),
    .rst_n        (rst_n),
    .wen          (wen),
    .ren          (ren),
    .clear        (clear),
    .wptr         (wptr),
    .rptr         (rptr),
    .arr_push     (arr_push),
    .head_wr      (head_wr),
    .head_ld      (head_ld),
    .head_valid   (head_valid),
    .empty        (empty),
    .full         (full),
    .almost_empty (almost_empty),
    .almost_full  (almost_full),
    .err          (err),
    .used_slots   (used_slots),
    .free_slots   (free_slots)
  );

  always_ff @(posedge clk) begin
    if (arr_push) mem[wptr] <= wdata;
  end

  assign arr_head = mem[rptr];

  if (OUT_REG != 0) begin : g_head
    logic [WIDTH-1:0] head;
    always_ff @(posedge clk) begin
      if (!rst_n || clear) head <= '0;
      else if (head_wr)    head <= wdata;
      else if (head_ld)    head <= arr_head;
    end
    assign raw = head;
  end else begin : g_comb
    assign raw = arr_head;
  end

  always_comb begin
    no_data = (OUT_REG != 0) ? !head_valid : empty;
    rdata   = raw;
    if (DATA_RESET != 0 && no_data) rdata = '0;
  end

  assign underflow = err[ERR_UF];
  assign overflow  = err[ERR_OF];

  if (UNDERFLOW_ASSERT != 0) begin : g_uf_chk
    assert property (@(posedge clk) disable iff (!rst_n || clear)
      !(ren && empty))
      else $error("nx_fifo_flex: read while empty");
  end

  if (OVERFLOW_ASSERT != 0) begin : g_of_chk
    assert property (@(posedge clk) disable iff (!rst_n || clear)
      !(wen && full && !ren))
      else $error("nx_fifo_flex: write while full");
  end

endmodule
